// File: rtl/cpu_controller_if.sv
// Control bundle between the accumulator datapath and its multi-cycle controller.
// The controller side (master) drives every load, select and write strobe.
interface cpu_controller_if;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned JSEL_W = 2;
  localparam int unsigned ASEL_W = 2;
  localparam int unsigned ALU_W  = 3;
  localparam int unsigned SHFT_W = 2;

  logic [DATA_W-1:0] INSTR;
  logic [DATA_W-1:0] accout;
  logic              enter;

  logic              IRload;
  logic [JSEL_W-1:0] Jmpmuxsel;
  logic              PCload;
  logic              MemInst;
  logic              MRload;
  logic [ASEL_W-1:0] Asel;
  logic              Aload;
  logic              RFwr;
  logic [ALU_W-1:0]  ALUsel;
  logic [SHFT_W-1:0] Shiftsel;
  logic              outen;
  logic              halted;

  modport master (
    input  INSTR, accout, enter,
    output IRload, Jmpmuxsel, PCload, MemInst, MRload, Asel, Aload,
           RFwr, ALUsel, Shiftsel, outen, halted
  );

  modport slave (
    output INSTR, accout, enter,
    input  IRload, Jmpmuxsel, PCload, MemInst, MRload, Asel, Aload,
           RFwr, ALUsel, Shiftsel, outen, halted
  );
endinterface

// File: rtl/cpu_controller.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator datapath.
// Outputs are decoded from the current state and INSTR so each strobe lands in its own state.
module cpu_controller #(
  parameter bit INWAIT_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  cpu_controller_if.master bus
);

  localparam int unsigned OP_W = 3;

  typedef enum logic [3:0] {
    S_START, S_FETCH, S_DECODE, S_EXEC, S_ADDR,
    S_MEM, S_JADDR, S_INWAIT, S_HALT
  } state_t;

  state_t state;

  logic [1:0]      cls;
  logic [OP_W-1:0] op;
  logic            grp0, is_in, is_ldm, is_jmp, is_halt, acc_zero;

  assign cls      = bus.INSTR[7:6];
  assign op       = bus.INSTR[5:3];
  assign grp0     = (cls == 2'b00);
  assign is_in    = grp0 && (op == 3'b010);
  assign is_ldm   = grp0 && (op == 3'b110);
  assign is_jmp   = grp0 && (op == 3'b111) && (bus.INSTR[2:0] == 3'b000);
  assign is_halt  = grp0 && (op == 3'b111) && (bus.INSTR[2:0] == 3'b111);
  assign acc_zero = (bus.accout == 8'h00);

  // State sequencing; reset wins from every state, including mid-LDM and S_INWAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_START;
    end else begin
      case (state)
        S_START:  state <= S_FETCH;
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          if (is_ldm)                  state <= S_ADDR;
          else if (is_jmp)             state <= S_JADDR;
          else if (is_halt)            state <= S_HALT;
          else if (is_in && INWAIT_EN) state <= S_INWAIT;
          else                         state <= S_EXEC;
        end
        S_EXEC:   state <= S_FETCH;
        S_ADDR:   state <= S_MEM;
        S_MEM:    state <= S_FETCH;
        S_JADDR:  state <= S_FETCH;
        S_INWAIT: state <= bus.enter ? S_FETCH : S_INWAIT;
        S_HALT:   state <= S_HALT;
        default:  state <= S_START;
      endcase
    end
  end

  // Datapath strobes and selects for the current state.
  always_comb begin
    bus.IRload    = 1'b0;
    bus.Jmpmuxsel = 2'b00;
    bus.PCload    = 1'b0;
    bus.MemInst   = 1'b0;
    bus.MRload    = 1'b0;
    bus.Asel      = 2'b00;
    bus.Aload     = 1'b0;
    bus.RFwr      = 1'b0;
    bus.ALUsel    = 3'b000;
    bus.Shiftsel  = 2'b00;
    bus.outen     = 1'b0;
    bus.halted    = 1'b0;

    case (state)
      S_FETCH: begin
        bus.IRload = 1'b1;
        bus.PCload = 1'b1;
      end
      S_EXEC: begin
        case (cls)
          2'b01: begin
            bus.ALUsel = op;
            bus.Aload  = 1'b1;
          end
          2'b10: if (acc_zero) begin
            bus.PCload    = 1'b1;
            bus.Jmpmuxsel = 2'b11;
          end
          2'b11: if (!acc_zero) begin
            bus.PCload    = 1'b1;
            bus.Jmpmuxsel = 2'b10;
          end
          default: begin
            case (op)
              3'b000: begin
                bus.Asel  = 2'b01;
                bus.Aload = 1'b1;
              end
              3'b001: bus.RFwr = 1'b1;
              // Only reached for IN when the enter handshake is disabled.
              3'b010: begin
                bus.Asel  = 2'b10;
                bus.Aload = 1'b1;
              end
              3'b011: bus.outen = 1'b1;
              3'b100: begin
                bus.Shiftsel = 2'b01;
                bus.Aload    = 1'b1;
              end
              3'b101: begin
                bus.Shiftsel = 2'b10;
                bus.Aload    = 1'b1;
              end
              default: ;
            endcase
          end
        endcase
      end
      S_ADDR: begin
        bus.MRload = 1'b1;
        bus.PCload = 1'b1;
      end
      S_MEM: begin
        bus.MemInst = 1'b1;
        bus.Asel    = 2'b11;
        bus.Aload   = 1'b1;
      end
      S_JADDR: begin
        bus.PCload    = 1'b1;
        bus.Jmpmuxsel = 2'b01;
      end
      S_INWAIT: if (bus.enter) begin
        bus.Asel  = 2'b10;
        bus.Aload = 1'b1;
      end
      S_HALT: bus.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller: walks each instruction class state by state
// and compares the packed control vector against hand-written expectations.
module tb_cpu_controller;
  logic clk = 1'b0;
  logic reset;

  cpu_controller_if bus();

  cpu_controller #(.INWAIT_EN(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // {IRload, Jmpmuxsel, PCload, MemInst, MRload, Asel, Aload, RFwr, ALUsel, Shiftsel, outen, halted}
  logic [16:0] obs;
  assign obs = {bus.IRload, bus.Jmpmuxsel, bus.PCload, bus.MemInst, bus.MRload,
                bus.Asel, bus.Aload, bus.RFwr, bus.ALUsel, bus.Shiftsel,
                bus.outen, bus.halted};

  function automatic logic [16:0] mk(input logic ir, input logic [1:0] jm, input logic pc,
                                     input logic mi, input logic mr, input logic [1:0] as,
                                     input logic al, input logic rf, input logic [2:0] alu,
                                     input logic [1:0] sh, input logic oe, input logic h);
    return {ir, jm, pc, mi, mr, as, al, rf, alu, sh, oe, h};
  endfunction

  logic [16:0] v_zero, v_fetch, v_inload, v_halt;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.INSTR = 8'h00; bus.accout = 8'h00; bus.enter = 1'b0;
    step(); step(); #1;
    n_cmp++; if (obs !== v_zero) begin n_bad++; $display("FAIL reset_hold: got %h want %h", obs, v_zero); end
    reset = 1'b0; #1;
    n_cmp++; if (obs !== v_zero) begin n_bad++; $display("FAIL reset_start: got %h want %h", obs, v_zero); end
    step(); #1;
    n_cmp++; if (obs !== v_fetch) begin n_bad++; $display("FAIL reset_fetch: got %h want %h", obs, v_fetch); end
  endtask

  // Single-exec-cycle instructions: FETCH -> DECODE -> EXEC -> FETCH.
  task automatic test_ops();
    logic [7:0]  ins [8];
    logic [16:0] exp [8];
    ins[0] = 8'h53; exp[0] = mk(0, 2'b00, 0, 0, 0, 2'b00, 1, 0, 3'b010, 2'b00, 0, 0);
    ins[1] = 8'h7F; exp[1] = mk(0, 2'b00, 0, 0, 0, 2'b00, 1, 0, 3'b111, 2'b00, 0, 0);
    ins[2] = 8'h03; exp[2] = mk(0, 2'b00, 0, 0, 0, 2'b01, 1, 0, 3'b000, 2'b00, 0, 0);
    ins[3] = 8'h0B; exp[3] = mk(0, 2'b00, 0, 0, 0, 2'b00, 0, 1, 3'b000, 2'b00, 0, 0);
    ins[4] = 8'h18; exp[4] = mk(0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 3'b000, 2'b00, 1, 0);
    ins[5] = 8'h20; exp[5] = mk(0, 2'b00, 0, 0, 0, 2'b00, 1, 0, 3'b000, 2'b01, 0, 0);
    ins[6] = 8'h28; exp[6] = mk(0, 2'b00, 0, 0, 0, 2'b00, 1, 0, 3'b000, 2'b10, 0, 0);
    ins[7] = 8'h3A; exp[7] = v_zero;
    for (int i = 0; i < 8; i++) begin
      bus.INSTR = ins[i];
      step(); #1;
      n_cmp++; if (obs !== v_zero) begin n_bad++; $display("FAIL op%0d_decode: got %h want %h", i, obs, v_zero); end
      step(); #1;
      n_cmp++; if (obs !== exp[i]) begin n_bad++; $display("FAIL op%0d_exec (%h): got %h want %h", i, ins[i], obs, exp[i]); end
      step(); #1;
      n_cmp++; if (obs !== v_fetch) begin n_bad++; $display("FAIL op%0d_fetch: got %h want %h", i, obs, v_fetch); end
    end
  endtask

  task automatic test_branch();
    logic [7:0]  ins [5];
    logic [7:0]  acc [5];
    logic [16:0] exp [5];
    ins[0] = 8'h85; acc[0] = 8'h00; exp[0] = mk(0, 2'b11, 1, 0, 0, 2'b00, 0, 0, 3'b000, 2'b00, 0, 0);
    ins[1] = 8'h85; acc[1] = 8'h01; exp[1] = v_zero;
    ins[2] = 8'hC3; acc[2] = 8'h05; exp[2] = mk(0, 2'b10, 1, 0, 0, 2'b00, 0, 0, 3'b000, 2'b00, 0, 0);
    ins[3] = 8'hC3; acc[3] = 8'h00; exp[3] = v_zero;
    ins[4] = 8'h80; acc[4] = 8'h00; exp[4] = mk(0, 2'b11, 1, 0, 0, 2'b00, 0, 0, 3'b000, 2'b00, 0, 0);
    for (int i = 0; i < 5; i++) begin
      bus.INSTR = ins[i]; bus.accout = acc[i];
      step(); step(); #1;
      n_cmp++; if (obs !== exp[i]) begin n_bad++; $display("FAIL br%0d_exec (%h acc=%h): got %h want %h", i, ins[i], acc[i], obs, exp[i]); end
      step(); #1;
      n_cmp++; if (obs !== v_fetch) begin n_bad++; $display("FAIL br%0d_fetch: got %h want %h", i, obs, v_fetch); end
    end
    bus.accout = 8'h00;
  endtask

  task automatic test_ldm();
    logic [16:0] v_addr, v_mem;
    v_addr = mk(0, 2'b00, 1, 0, 1, 2'b00, 0, 0, 3'b000, 2'b00, 0, 0);
    v_mem  = mk(0, 2'b00, 0, 1, 0, 2'b11, 1, 0, 3'b000, 2'b00, 0, 0);
    bus.INSTR = 8'h30;
    step(); #1;
    n_cmp++; if (obs !== v_zero) begin n_bad++; $display("FAIL ldm_decode: got %h want %h", obs, v_zero); end
    step(); #1;
    n_cmp++; if (obs !== v_addr) begin n_bad++; $display("FAIL ldm_addr: got %h want %h", obs, v_addr); end
    bus.INSTR = 8'h25;
    step(); #1;
    n_cmp++; if (obs !== v_mem) begin n_bad++; $display("FAIL ldm_mem: got %h want %h", obs, v_mem); end
    step(); #1;
    n_cmp++; if (obs !== v_fetch) begin n_bad++; $display("FAIL ldm_fetch: got %h want %h", obs, v_fetch); end
  endtask

  task automatic test_jmp();
    logic [16:0] v_jaddr;
    v_jaddr = mk(0, 2'b01, 1, 0, 0, 2'b00, 0, 0, 3'b000, 2'b00, 0, 0);
    bus.INSTR = 8'h38;
    step(); step(); #1;
    n_cmp++; if (obs !== v_jaddr) begin n_bad++; $display("FAIL jmp_jaddr: got %h want %h", obs, v_jaddr); end
    step(); #1;
    n_cmp++; if (obs !== v_fetch) begin n_bad++; $display("FAIL jmp_fetch: got %h want %h", obs, v_fetch); end
  endtask

  task automatic test_in();
    bus.INSTR = 8'h10; bus.enter = 1'b0;
    step();
    for (int i = 0; i < 7; i++) begin
      step(); #1;
      n_cmp++; if (obs !== v_zero) begin n_bad++; $display("FAIL in_wait%0d: got %h want %h", i, obs, v_zero); end
    end
    bus.enter = 1'b1; #1;
    n_cmp++; if (obs !== v_inload) begin n_bad++; $display("FAIL in_enter: got %h want %h", obs, v_inload); end
    step(); #1;
    n_cmp++; if (obs !== v_fetch) begin n_bad++; $display("FAIL in_fetch: got %h want %h", obs, v_fetch); end
    // enter still high: the next IN consumes it once, and DECODE ignores it
    step(); #1;
    n_cmp++; if (obs !== v_zero) begin n_bad++; $display("FAIL in2_decode: got %h want %h", obs, v_zero); end
    step(); #1;
    n_cmp++; if (obs !== v_inload) begin n_bad++; $display("FAIL in2_enter: got %h want %h", obs, v_inload); end
    step(); #1;
    n_cmp++; if (obs !== v_fetch) begin n_bad++; $display("FAIL in2_fetch: got %h want %h", obs, v_fetch); end
    bus.enter = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.INSTR = 8'h30;
    step(); step(); step(); #1;
    n_cmp++; if (obs[10] !== 1'b1) begin n_bad++; $display("FAIL rmid_in_mem: got %b want 1", obs[10]); end
    reset = 1'b1;
    step(); #1;
    n_cmp++; if (obs !== v_zero) begin n_bad++; $display("FAIL rmid_start: got %h want %h", obs, v_zero); end
    reset = 1'b0;
    step(); #1;
    n_cmp++; if (obs !== v_fetch) begin n_bad++; $display("FAIL rmid_fetch: got %h want %h", obs, v_fetch); end
    bus.INSTR = 8'h10;
    step(); step(); reset = 1'b1;
    step(); #1;
    n_cmp++; if (obs !== v_zero) begin n_bad++; $display("FAIL rwait_start: got %h want %h", obs, v_zero); end
    reset = 1'b0;
    step(); #1;
    n_cmp++; if (obs !== v_fetch) begin n_bad++; $display("FAIL rwait_fetch: got %h want %h", obs, v_fetch); end
  endtask

  task automatic test_halt();
    bus.INSTR = 8'h3F;
    step(); #1;
    n_cmp++; if (obs !== v_zero) begin n_bad++; $display("FAIL halt_decode: got %h want %h", obs, v_zero); end
    for (int i = 0; i < 20; i++) begin
      bus.enter = i[0];
      step(); #1;
      n_cmp++; if (obs !== v_halt) begin n_bad++; $display("FAIL halt_hold%0d: got %h want %h", i, obs, v_halt); end
    end
    bus.enter = 1'b0; reset = 1'b1;
    step(); #1;
    n_cmp++; if (obs !== v_zero) begin n_bad++; $display("FAIL halt_reset: got %h want %h", obs, v_zero); end
    reset = 1'b0;
    step(); #1;
    n_cmp++; if (obs !== v_fetch) begin n_bad++; $display("FAIL halt_fetch: got %h want %h", obs, v_fetch); end
  endtask

  initial begin
    v_zero   = '0;
    v_fetch  = mk(1, 2'b00, 1, 0, 0, 2'b00, 0, 0, 3'b000, 2'b00, 0, 0);
    v_inload = mk(0, 2'b00, 0, 0, 0, 2'b10, 1, 0, 3'b000, 2'b00, 0, 0);
    v_halt   = mk(0, 2'b00, 0, 0, 0, 2'b00, 0, 0, 3'b000, 2'b00, 0, 1);
    test_reset();
    test_ops();
    test_branch();
    test_ldm();
    test_jmp();
    test_in();
    test_reset_mid();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
